// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared mode encoding, default timing constants and counter sizing helper
package mode_pkg;

    // Displayed mode; 2'd3 is unused and recovers to CLOCK.
    typedef enum logic [1:0] {
        CLOCK     = 2'd0,
        STOPWATCH = 2'd1,
        COUNTDOWN = 2'd2
    } mode_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;     // 10 ms at 50 MHz
    localparam int DEFAULT_ALARM_CYCLES    = 250000000;  // 5 s at 50 MHz

    // Width of a counter that must hold the values 0 .. cycles-1.
    function automatic int count_width(input int cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - synchroniser, stability counter and press pulse for one push-button
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   btn    raw active-high button, asynchronous to clk
//   press  one-cycle pulse on each accepted rising edge of the debounced level
module button_debounce
    import mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int            CW       = count_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [1:0]    sync_vld;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_q;
    logic          armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync     <= 2'b00;
            sync_vld <= 2'b00;
            cnt      <= '0;
            level    <= 1'b0;
            level_q  <= 1'b0;
            armed    <= 1'b0;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], btn};
            sync_vld <= {sync_vld[0], 1'b1};

            // A button held through reset must be seen released once before
            // it can produce a press; sync_vld masks the reset value of sync.
            if (sync_vld[1] && !sync[1]) begin
                armed <= 1'b1;
            end

            if (sync[1] != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end

            level_q <= level;
            press   <= level & ~level_q & armed;
        end
    end

endmodule

// File: rtl/mode_controller.sv
// rtl/mode_controller.sv - front-panel mode FSM, per-engine run/pause, clear pulses and expiry alarm
//
// Ports:
//   clk, reset                      system clock, asynchronous active-low reset
//   btn_mode, btn_start, btn_clear  raw active-high push-buttons
//   cd_zero                         countdown engine reads zero
//   sel_clock/stopwatch/countdown   one-hot displayed mode
//   pause_clock/sw/cd               1 = engine frozen
//   clr_clock/sw/cd                 one-cycle clear pulse per engine
//   alarm                           countdown expiry alarm
module mode_controller
    import mode_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int ALARM_CYCLES    = DEFAULT_ALARM_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_mode,
    input  logic btn_start,
    input  logic btn_clear,
    input  logic cd_zero,
    output logic sel_clock,
    output logic sel_stopwatch,
    output logic sel_countdown,
    output logic pause_clock,
    output logic pause_sw,
    output logic pause_cd,
    output logic clr_clock,
    output logic clr_sw,
    output logic clr_cd,
    output logic alarm
);

    localparam int            AW         = count_width(ALARM_CYCLES);
    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYCLES - 1);

    logic mode_press;
    logic start_press;
    logic clear_press;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_mode),
        .press (mode_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_start),
        .press (start_press)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_clear),
        .press (clear_press)
    );

    mode_t         state, state_n;
    logic          pause_clock_n, pause_sw_n, pause_cd_n;
    logic          clr_clock_n, clr_sw_n, clr_cd_n;
    logic          alarm_n;
    logic [AW-1:0] alarm_cnt, alarm_cnt_n;
    logic          any_press;

    assign any_press = mode_press | start_press | clear_press;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= CLOCK;
            sel_clock     <= 1'b1;
            sel_stopwatch <= 1'b0;
            sel_countdown <= 1'b0;
            pause_clock   <= 1'b0;
            pause_sw      <= 1'b1;
            pause_cd      <= 1'b1;
            clr_clock     <= 1'b0;
            clr_sw        <= 1'b0;
            clr_cd        <= 1'b0;
            alarm         <= 1'b0;
            alarm_cnt     <= '0;
        end else begin
            state         <= state_n;
            sel_clock     <= (state_n != STOPWATCH) && (state_n != COUNTDOWN);
            sel_stopwatch <= (state_n == STOPWATCH);
            sel_countdown <= (state_n == COUNTDOWN);
            pause_clock   <= pause_clock_n;
            pause_sw      <= pause_sw_n;
            pause_cd      <= pause_cd_n;
            clr_clock     <= clr_clock_n;
            clr_sw        <= clr_sw_n;
            clr_cd        <= clr_cd_n;
            alarm         <= alarm_n;
            alarm_cnt     <= alarm_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        pause_clock_n = pause_clock;
        pause_sw_n    = pause_sw;
        pause_cd_n    = pause_cd;
        clr_clock_n   = 1'b0;
        clr_sw_n      = 1'b0;
        clr_cd_n      = 1'b0;
        alarm_n       = alarm;
        alarm_cnt_n   = alarm_cnt;

        if (alarm && any_press) begin
            // The press only silences the alarm.
            alarm_n     = 1'b0;
            alarm_cnt_n = '0;
        end else begin
            if (alarm) begin
                if (alarm_cnt == '0) begin
                    alarm_n = 1'b0;
                end else begin
                    alarm_cnt_n = alarm_cnt - 1'b1;
                end
            end

            // Priority mode > clear > start; losers are dropped.
            if (mode_press) begin
                case (state)
                    CLOCK:     state_n = STOPWATCH;
                    STOPWATCH: state_n = COUNTDOWN;
                    default:   state_n = CLOCK;
                endcase
            end else if (clear_press) begin
                case (state)
                    STOPWATCH: begin
                        clr_sw_n   = 1'b1;
                        pause_sw_n = 1'b1;
                    end
                    COUNTDOWN: begin
                        clr_cd_n   = 1'b1;
                        pause_cd_n = 1'b1;
                    end
                    default: clr_clock_n = 1'b1;
                endcase
            end else if (start_press) begin
                case (state)
                    STOPWATCH: pause_sw_n = ~pause_sw;
                    COUNTDOWN: begin
                        if (!cd_zero) begin
                            pause_cd_n = ~pause_cd;
                        end
                    end
                    default: pause_clock_n = ~pause_clock;
                endcase
            end
        end

        // Expiry acts in any displayed mode and cannot retrigger while paused.
        if (!pause_cd && cd_zero) begin
            pause_cd_n  = 1'b1;
            alarm_n     = 1'b1;
            alarm_cnt_n = ALARM_LAST;
        end
    end

endmodule

// File: doc/mode_controller.md
Name: mode_controller

Overview:
Front-panel sequencer for the multi-mode timepiece (clock / stopwatch / countdown). It debounces the three raw push-buttons and tracks the active display mode with an FSM. It also keeps an independent run/pause flag per timing engine and issues per-engine clear pulses. It drives the countdown-expiry alarm. Its outputs replace the static clock/stopwatch/countdown select switches and the shared pause/reset inputs at the top level.

Parameters:
DEBOUNCE_CYCLES, 500000, number of consecutive stable clk samples before a button level is accepted (10 ms at 50 MHz)
ALARM_CYCLES, 250000000, length of the alarm after countdown expiry (5 s at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
btn_mode  input  1  raw mode button, active-high, asynchronous to clk
btn_start  input  1  raw start/pause button, active-high, asynchronous
btn_clear  input  1  raw clear button, active-high, asynchronous
cd_zero  input  1  countdown engine reports 00 (registered in engine)
sel_clock  output  1  one-hot mode select: clock
sel_stopwatch  output  1  one-hot mode select: stopwatch
sel_countdown  output  1  one-hot mode select: countdown
pause_clock  output  1  1 = clock engine frozen
pause_sw  output  1  1 = stopwatch frozen
pause_cd  output  1  1 = countdown frozen
clr_clock  output  1  one-cycle clear pulse to clock engine
clr_sw  output  1  one-cycle clear pulse to stopwatch
clr_cd  output  1  one-cycle clear pulse to countdown
alarm  output  1  high while the expiry alarm is active

Behaviour:
- Reset (reset=0, async): mode=CLOCK, so sel_clock=1 and the other two selects are 0. pause_clock=0, pause_sw=1, pause_cd=1. All clr_*=0, alarm=0, debouncers cleared to level 0, alarm counter=0.
- All outputs are registered. Selects are always exactly one-hot.
- Button path, per button:
  - 2-flop synchroniser, then a stability counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronised samples that differ from the current level. Any mismatch restarts the count.
  - A rising edge of the debounced level produces a 1-cycle press pulse. Release produces nothing.
  - Latency from a clean raw edge to the press pulse is 2 + DEBOUNCE_CYCLES + 1 clocks.
- Mode FSM:
  - States CLOCK → STOPWATCH → COUNTDOWN → CLOCK, advanced by the mode press.
  - The select outputs update the cycle after the press.
  - Engines not on display keep their run state (the clock keeps time while the stopwatch is shown).
- Start press toggles the run flag of the displayed engine only; pause_x = ~run_x.
  - Exception: in COUNTDOWN with cd_zero=1, start is ignored, so the countdown cannot be run from zero.
- Clear press pulses clr_x for the displayed engine for exactly 1 cycle.
  - Stopwatch and countdown: the clear also forces the run flag to 0.
  - Clock: the run flag is unchanged.
- Simultaneous presses in one cycle: priority mode > clear > start. Lower-priority presses in that cycle are discarded, not queued.
- Expiry:
  - When run_cd=1 and cd_zero=1, the next cycle sets run_cd=0 (pause_cd=1), alarm=1, and loads the alarm counter with ALARM_CYCLES-1. This happens regardless of the displayed mode.
  - alarm falls after ALARM_CYCLES cycles high, or on the cycle after any press.
  - A press that terminates the alarm is consumed and performs no other action.
  - cd_zero held high after expiry does not retrigger the alarm, because run_cd is 0.
- Reset mid-debounce or mid-alarm returns every register to the reset values immediately. No press pulse is produced on reset release, even if a button is held.

Decomposition:
- Shared package mode_pkg holds:
  - the mode state encoding (CLOCK=2'd0, STOPWATCH=2'd1, COUNTDOWN=2'd2);
  - the default DEBOUNCE_CYCLES and ALARM_CYCLES values;
  - a helper that returns the counter width for a cycle count.
- One sub-module, button_debounce (synchroniser + stability counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.
- The FSM, run flags and alarm stay in mode_controller.

Test Plan (DEBOUNCE_CYCLES=4, ALARM_CYCLES=10):
- Reset release, no buttons → sel_clock=1, pause_clock=0, pause_sw=1, pause_cd=1, alarm=0.
- Three clean mode presses → selects step STOPWATCH, COUNTDOWN, CLOCK. Each change lands 2+4+1+1 clocks after the raw edge.
- btn_start bounces 1-0-1 with 2-cycle glitches, then holds 1 for 6 cycles → exactly one start press. In STOPWATCH, pause_sw goes 1→0 and pause_clock is unchanged.
- Countdown running (pause_cd=0), switch to CLOCK, assert cd_zero → next cycle pause_cd=1 and alarm=1. alarm stays high 10 cycles, then 0. sel_clock stays 1.
- During the alarm, press clear → alarm drops the next cycle, clr_cd stays 0, and the mode is unchanged.
- mode and start presses land in the same cycle while in STOPWATCH → mode advances to COUNTDOWN, pause_sw unchanged, pause_cd unchanged. Then reset is asserted mid-debounce → all outputs return to reset values asynchronously.
